// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command parser and the ALU itself.
package alu_cmd_pkg;

  // Default frame start marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Error codes reported on err_code alongside err_valid
  localparam logic [1:0] ERR_CHK = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_OVR = 2'b10;
  localparam logic [1:0] ERR_OPC = 2'b11;

  // Parser states; OPC..BL are consecutive so the payload states can step by +1
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPC   = 3'd1,
    ST_AH    = 3'd2,
    ST_AL    = 3'd3,
    ST_BH    = 3'd4,
    ST_BL    = 3'd5,
    ST_CHK   = 3'd6,
    ST_ISSUE = 3'd7
  } state_e;

  // Operation encoding shared with the ALU
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_CMP = 4'd7
  } alu_op_e;

  // Fold one byte into the running XOR checksum
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/alu_cmd_parser_byte_gap_timer.sv
// Idle-gap timer: counts cycles between accepted bytes while a frame is open.
module byte_gap_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] timer_r;

  // Count idle cycles; any accepted byte or leaving the frame states zeroes the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= {TW{1'b0}};
    end else if (clear || !enable) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  assign expired = enable && (timer_r == LAST);

endmodule

// File: rtl/alu_cmd_parser.sv
// Frames UART bytes into ALU commands (sync, opcode, A, B, XOR checksum) and
// hands them to the ALU over valid/ready; bad traffic raises a one-cycle error.
module alu_cmd_parser
  import alu_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         OP_W        = 4,
  parameter int         NUM_OPS     = 8,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [OP_W-1:0] opcode,
  output logic [15:0]     a,
  output logic [15:0]     b,
  output logic            err_valid,
  output logic [1:0]      err_code,
  output logic [7:0]      frame_cnt
);

  state_e          state_r, state_s;
  logic [7:0]      xor_r, xor_s;
  logic [7:0]      opc_r, opc_s, ah_r, ah_s, al_r, al_s, bh_r, bh_s, bl_r, bl_s;
  logic            op_valid_r, op_valid_s;
  logic [OP_W-1:0] opcode_r, opcode_s;
  logic [15:0]     a_r, a_s, b_r, b_s;
  logic            err_valid_r, err_valid_s;
  logic [1:0]      err_code_r, err_code_s;
  logic [7:0]      frame_cnt_r, frame_cnt_s;
  logic            gap_en_s, gap_expired_s;
  logic            opc_bad_s;

  assign gap_en_s  = (state_r != ST_IDLE) && (state_r != ST_ISSUE);
  // Opcode is rejected if it has bits above the output width or is beyond the op table
  assign opc_bad_s = ((opc_r >> OP_W) != 8'd0) || (int'({24'd0, opc_r}) >= NUM_OPS);

  byte_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid),
    .enable  (gap_en_s),
    .expired (gap_expired_s)
  );

  // Next-state, staging, checksum, error and output decisions
  always_comb begin
    state_s     = state_r;
    xor_s       = xor_r;
    opc_s       = opc_r;
    ah_s        = ah_r;
    al_s        = al_r;
    bh_s        = bh_r;
    bl_s        = bl_r;
    opcode_s    = opcode_r;
    a_s         = a_r;
    b_s         = b_r;
    err_valid_s = 1'b0;
    err_code_s  = err_code_r;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_s = ST_OPC;
          xor_s   = 8'h00;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_OPC, ST_AH, ST_AL, ST_BH, ST_BL: begin
        if (rx_valid) begin
          xor_s = xor_fold(xor_r, rx_data);
          case (state_r)
            ST_OPC:  opc_s = rx_data;
            ST_AH:   ah_s  = rx_data;
            ST_AL:   al_s  = rx_data;
            ST_BH:   bh_s  = rx_data;
            ST_BL:   bl_s  = rx_data;
            default: opc_s = opc_r;
          endcase
          state_s = state_e'(state_r + 3'd1);
        end else if (gap_expired_s) begin
          err_valid_s = 1'b1;
          err_code_s  = ERR_TMO;
          state_s     = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (xor_r != rx_data) begin
            err_valid_s = 1'b1;
            err_code_s  = ERR_CHK;
            state_s     = ST_IDLE;
          end else if (opc_bad_s) begin
            err_valid_s = 1'b1;
            err_code_s  = ERR_OPC;
            state_s     = ST_IDLE;
          end else begin
            opcode_s = opc_r[OP_W-1:0];
            a_s      = {ah_r, al_r};
            b_s      = {bh_r, bl_r};
            state_s  = ST_ISSUE;
          end
        end else if (gap_expired_s) begin
          err_valid_s = 1'b1;
          err_code_s  = ERR_TMO;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_CHK;
        end
      end
      ST_ISSUE: begin
        if (op_ready) begin
          // Handshake cycle: a byte arriving now is treated as an IDLE byte
          frame_cnt_s = frame_cnt_r + 8'd1;
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_s = ST_OPC;
            xor_s   = 8'h00;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (rx_valid) begin
          err_valid_s = 1'b1;
          err_code_s  = ERR_OVR;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    op_valid_s = (state_s == ST_ISSUE);
  end

  // State, staging and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      xor_r       <= 8'h00;
      opc_r       <= 8'h00;
      ah_r        <= 8'h00;
      al_r        <= 8'h00;
      bh_r        <= 8'h00;
      bl_r        <= 8'h00;
      op_valid_r  <= 1'b0;
      opcode_r    <= {OP_W{1'b0}};
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
      err_valid_r <= 1'b0;
      err_code_r  <= 2'b00;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      xor_r       <= xor_s;
      opc_r       <= opc_s;
      ah_r        <= ah_s;
      al_r        <= al_s;
      bh_r        <= bh_s;
      bl_r        <= bl_s;
      op_valid_r  <= op_valid_s;
      opcode_r    <= opcode_s;
      a_r         <= a_s;
      b_r         <= b_s;
      err_valid_r <= err_valid_s;
      err_code_r  <= err_code_s;
      frame_cnt_r <= frame_cnt_s;
    end
  end

  assign op_valid  = op_valid_r;
  assign opcode    = opcode_r;
  assign a         = a_r;
  assign b         = b_r;
  assign err_valid = err_valid_r;
  assign err_code  = err_code_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Bench for alu_cmd_parser: directed scenarios plus random framed traffic,
// checked every cycle against a frame-buffer reference model.
module tb_alu_cmd_parser;
  import alu_cmd_pkg::*;

  localparam int         TMO  = 16;
  localparam int         NOPS = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        op_ready = 1'b0;
  logic        op_valid;
  logic [3:0]  opcode;
  logic [15:0] a, b;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  alu_cmd_parser #(.SYNC_BYTE(SYNC), .OP_W(4), .NUM_OPS(NOPS), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .a(a), .b(b),
    .err_valid(err_valid), .err_code(err_code), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: collects frame bytes in a queue and judges the whole frame at once
  bit          m_in_frame, m_pending, m_err;
  logic [7:0]  m_buf[$];
  int          m_gap;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_code;
  logic [7:0]  m_cnt;

  task automatic model_reset();
    m_in_frame = 1'b0; m_pending = 1'b0; m_err = 1'b0; m_buf.delete(); m_gap = 0;
    m_op = 4'd0; m_a = 16'd0; m_b = 16'd0; m_code = 2'b00; m_cnt = 8'd0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
    logic [7:0] x, ob;
    m_err = 1'b0;
    if (m_pending) begin
      if (rdy) begin
        m_pending = 1'b0;
        m_cnt = m_cnt + 8'd1;
        if (v && d == SYNC) begin m_in_frame = 1'b1; m_buf.delete(); m_gap = 0; end
      end else if (v) begin
        m_err = 1'b1; m_code = ERR_OVR;
      end
    end else if (m_in_frame) begin
      if (v) begin
        m_buf.push_back(d);
        m_gap = 0;
        if (m_buf.size() == 6) begin
          m_in_frame = 1'b0;
          x  = m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3] ^ m_buf[4];
          ob = m_buf[0];
          if (x != m_buf[5]) begin
            m_err = 1'b1; m_code = ERR_CHK;
          end else if (int'(ob) >= NOPS) begin
            m_err = 1'b1; m_code = ERR_OPC;
          end else begin
            m_pending = 1'b1;
            m_op = ob[3:0];
            m_a  = {m_buf[1], m_buf[2]};
            m_b  = {m_buf[3], m_buf[4]};
          end
        end
      end else if (m_gap == TMO - 1) begin
        m_err = 1'b1; m_code = ERR_TMO; m_in_frame = 1'b0;
      end else begin
        m_gap++;
      end
    end else if (v && d == SYNC) begin
      m_in_frame = 1'b1; m_buf.delete(); m_gap = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("op_valid", {31'd0, op_valid}, {31'd0, m_pending});
    check_eq("opcode", {28'd0, opcode}, {28'd0, m_op});
    check_eq("a", {16'd0, a}, {16'd0, m_a});
    check_eq("b", {16'd0, b}, {16'd0, m_b});
    check_eq("err_valid", {31'd0, err_valid}, {31'd0, m_err});
    check_eq("err_code", {30'd0, err_code}, {30'd0, m_code});
    check_eq("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    rx_valid = v; rx_data = d; op_ready = rdy;
    @(posedge clk);
    model_step(v, d, rdy);
    #1;
    compare_all();
  endtask

  task automatic send7(input logic [55:0] f, input bit rdy);
    for (int i = 0; i < 7; i++) cycle(1'b1, f[55-8*i -: 8], rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), rdy);
  endtask

  initial begin
    logic [7:0] f[7];
    int kind, gap;
    bit rdy;
    model_reset();
    #12;
    check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check_eq("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check_eq("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;

    // Good frame, held then accepted
    send7(56'hA5_01_12_34_00_10_37, 1'b0);
    check_eq("good_valid", {31'd0, op_valid}, 32'd1);
    check_eq("good_opcode", {28'd0, opcode}, 32'd1);
    check_eq("good_a", {16'd0, a}, 32'h1234);
    check_eq("good_b", {16'd0, b}, 32'h0010);
    cycle(1'b0, 8'h00, 1'b1);
    check_eq("good_cnt", {24'd0, frame_cnt}, 32'd1);
    check_eq("good_drop", {31'd0, op_valid}, 32'd0);

    // Bad checksum, then a good frame
    send7(56'hA5_01_12_34_00_10_38, 1'b1);
    check_eq("badchk_err", {29'd0, err_valid, err_code}, 32'h4);
    check_eq("badchk_nocmd", {31'd0, op_valid}, 32'd0);
    send7(56'hA5_01_12_34_00_10_37, 1'b1);
    idle(1, 1'b1);
    check_eq("after_badchk_cnt", {24'd0, frame_cnt}, 32'd2);

    // Sync hunt through garbage
    cycle(1'b1, 8'h00, 1'b1); cycle(1'b1, 8'hFF, 1'b1); cycle(1'b1, 8'h5A, 1'b1);
    check_eq("hunt_noerr", {31'd0, err_valid}, 32'd0);
    send7(56'hA5_01_12_34_00_10_37, 1'b1);
    idle(1, 1'b1);
    check_eq("hunt_cnt", {24'd0, frame_cnt}, 32'd3);

    // Timeout after 16 idle cycles
    cycle(1'b1, 8'hA5, 1'b1); cycle(1'b1, 8'h01, 1'b1);
    idle(16, 1'b1);
    check_eq("tmo_err", {29'd0, err_valid, err_code}, 32'h5);
    // Byte on the last allowed cycle is accepted
    cycle(1'b1, 8'hA5, 1'b1); cycle(1'b1, 8'h01, 1'b1);
    idle(15, 1'b1);
    cycle(1'b1, 8'h12, 1'b0);
    check_eq("tmo_edge_noerr", {31'd0, err_valid}, 32'd0);
    cycle(1'b1, 8'h34, 1'b0); cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'h10, 1'b0); cycle(1'b1, 8'h37, 1'b0);
    check_eq("tmo_edge_valid", {31'd0, op_valid}, 32'd1);

    // Overrun while held, then handshake with a SYNC on the same cycle
    cycle(1'b1, 8'h55, 1'b0);
    check_eq("ovr_err", {29'd0, err_valid, err_code}, 32'h6);
    check_eq("ovr_hold_a", {16'd0, a}, 32'h1234);
    check_eq("ovr_hold_valid", {31'd0, op_valid}, 32'd1);
    cycle(1'b1, 8'hA5, 1'b1);
    check_eq("b2b_cnt", {24'd0, frame_cnt}, 32'd4);
    check_eq("b2b_noerr", {31'd0, err_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [47:0] rest;
      rest = 48'h02_00_05_FF_FE_06;
      cycle(1'b1, rest[47-8*i -: 8], 1'b0);
    end
    check_eq("b2b_opcode", {28'd0, opcode}, 32'd2);
    check_eq("b2b_b", {16'd0, b}, 32'hFFFE);
    idle(1, 1'b1);

    // Bad opcode
    send7(56'hA5_09_00_01_00_02_0A, 1'b1);
    check_eq("badop_err", {29'd0, err_valid, err_code}, 32'h7);
    check_eq("badop_nocmd", {31'd0, op_valid}, 32'd0);

    // Randomized framed traffic
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      f[0] = SYNC;
      f[1] = (kind == 3) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      for (int i = 2; i < 6; i++) f[i] = 8'($urandom);
      f[6] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5];
      if (kind == 2) f[6] = f[6] ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 5) cycle(1'b1, 8'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 7; i++) begin
        gap = (kind == 4 && i == 3) ? $urandom_range(14, 17) : $urandom_range(0, 2);
        rdy = ($urandom_range(0, 3) != 0);
        idle(gap, rdy);
        cycle(1'b1, f[i], ($urandom_range(0, 3) != 0));
      end
    end
    idle(3, 1'b1);

    // Reset in the middle of a frame
    cycle(1'b1, 8'hA5, 1'b1); cycle(1'b1, 8'h01, 1'b1); cycle(1'b1, 8'h12, 1'b1);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    rst_n = 1'b1;
    send7(56'hA5_01_12_34_00_10_37, 1'b1);
    idle(1, 1'b1);
    check_eq("post_rst_cnt", {24'd0, frame_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
